// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I main control path: FSM states,
// opcode classes, PC-select codes, trap causes and the ALU_op constants.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_ILLEGAL
  } op_class_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] FPC_SEQ    = 2'b00;
  localparam logic [1:0] FPC_BRANCH = 2'b01;
  localparam logic [1:0] FPC_JALR   = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b01000;

  function automatic op_class_e classify(input logic [6:0] opcode);
    op_class_e cls;
    case (opcode)
      OPC_R:      cls = CLS_R;
      OPC_I:      cls = CLS_I;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      default:    cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_main_control_decode.sv
// Purely combinational instruction decode: opcode class, legality and the
// ALU-side controls that the FSM presents during EXECUTE.
module mc_decode
  import multicycle_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output op_class_e  op_class_o,
  output logic       illegal_o,
  output logic [4:0] alu_op_o,
  output logic [2:0] alu_branch_o,
  output logic       alu_src_o
);

  logic is_m;
  logic r_funct7_ok;

  assign is_m        = ENABLE_M && (funct7_i == F7_MULDIV);
  assign r_funct7_ok = (funct7_i == F7_BASE) || (funct7_i == F7_ALT) || is_m;

  always_comb begin
    op_class_o   = classify(opcode_i);
    illegal_o    = 1'b0;
    alu_op_o     = ALU_ADD;
    alu_branch_o = funct3_i;
    alu_src_o    = 1'b1;
    case (op_class_o)
      CLS_R: begin
        alu_src_o = 1'b0;
        illegal_o = !r_funct7_ok;
        alu_op_o  = is_m ? {2'b10, funct3_i} : {1'b0, funct7_i[5], funct3_i};
      end
      // Only the right shifts use bit 30 to pick arithmetic vs logical.
      CLS_I: alu_op_o = {1'b0, (funct3_i == 3'b101) ? funct7_i[5] : 1'b0, funct3_i};
      CLS_BRANCH: begin
        alu_src_o = 1'b0;
        alu_op_o  = ALU_SUB;
      end
      CLS_ILLEGAL: illegal_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Multi-cycle RV32I main control FSM: fetch/decode/execute/mem/writeback
// sequencing, memory timeout, stall freezing and sticky trap reporting.
module multicycle_main_control
  import multicycle_ctrl_pkg::*;
#(
  parameter bit          ENABLE_M    = 1'b0,
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter logic [31:0] RESET_IR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_rdata,
  input  logic        mem_ready,
  input  logic        stall,
  output logic        mem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemtoReg,
  output logic [4:0]  ALU_op,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic [2:0]  alu_branch,
  output logic        RegWrite,
  output logic [1:0]  fetchPC,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state
);

  // Memory handshake: mem_req stays high from the first cycle of FETCH/MEM
  // until the cycle mem_ready is high; that cycle completes the transfer and
  // the FSM advances on the following edge. No request is ever withdrawn.

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(MEM_TIMEOUT);

  state_e          state_q, state_d;
  logic [31:0]     ir_q;
  logic [CW-1:0]   count_q, count_d, count_inc;
  logic            trap_q, trap_d;
  logic [1:0]      cause_q, cause_d;

  op_class_e       cls;
  logic            dec_illegal;
  logic [4:0]      dec_alu_op;
  logic [2:0]      dec_alu_branch;
  logic            dec_alu_src;
  logic            is_load;
  logic            stall_hold;
  logic            unused_ir_bits;

  mc_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .opcode_i     (ir_q[6:0]),
    .funct3_i     (ir_q[14:12]),
    .funct7_i     (ir_q[31:25]),
    .op_class_o   (cls),
    .illegal_o    (dec_illegal),
    .alu_op_o     (dec_alu_op),
    .alu_branch_o (dec_alu_branch),
    .alu_src_o    (dec_alu_src)
  );

  assign unused_ir_bits = ^{ir_q[24:15], ir_q[11:7]};
  assign is_load        = (cls == CLS_LOAD);
  assign count_inc      = count_q + CW'(1);
  assign stall_hold     = stall && ((state_q == ST_DECODE) || (state_q == ST_EXECUTE) ||
                                    (state_q == ST_WRITEBACK));

  always_comb begin
    state_d    = state_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    mem_req    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    Branch     = 1'b0;
    MemRead    = 1'b0;
    MemtoReg   = 1'b0;
    ALU_op     = ALU_ADD;
    MemWrite   = 1'b0;
    ALUSrc     = 1'b0;
    alu_branch = 3'b000;
    RegWrite   = 1'b0;
    fetchPC    = FPC_SEQ;

    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!stall) begin
          if (dec_illegal) begin
            state_d = ST_TRAP;
            trap_d  = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end else begin
            state_d = ST_EXECUTE;
          end
        end
      end
      ST_EXECUTE: begin
        ALU_op     = dec_alu_op;
        ALUSrc     = dec_alu_src;
        alu_branch = dec_alu_branch;
        if (cls == CLS_BRANCH) begin
          // The datapath qualifies this PC update with the compare result.
          Branch   = 1'b1;
          pc_write = 1'b1;
          fetchPC  = FPC_BRANCH;
        end
        if (!stall) begin
          if (cls == CLS_BRANCH)                   state_d = ST_FETCH;
          else if (is_load || cls == CLS_STORE)    state_d = ST_MEM;
          else                                     state_d = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        MemRead  = is_load;
        MemWrite = !is_load;
        if (mem_ready) begin
          if (is_load) begin
            state_d = ST_WRITEBACK;
          end else begin
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end
        end
      end
      ST_WRITEBACK: begin
        RegWrite = 1'b1;
        MemtoReg = is_load;
        pc_write = 1'b1;
        case (cls)
          CLS_JAL:  fetchPC = FPC_BRANCH;
          CLS_JALR: fetchPC = FPC_JALR;
          default:  fetchPC = FPC_SEQ;
        endcase
        if (!stall) state_d = ST_FETCH;
      end
      ST_TRAP: ;
      default: state_d = ST_FETCH;
    endcase

    // A ready on the limit cycle completes normally: only unanswered cycles count.
    if ((MEM_TIMEOUT != 0) && mem_req && !mem_ready && (count_inc == TO_LIMIT)) begin
      state_d = ST_TRAP;
      trap_d  = 1'b1;
      cause_d = CAUSE_TIMEOUT;
    end

    if (stall_hold) begin
      RegWrite = 1'b0;
      pc_write = 1'b0;
      ir_write = 1'b0;
      MemWrite = 1'b0;
    end

    if (reset) begin
      mem_req    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      Branch     = 1'b0;
      MemRead    = 1'b0;
      MemtoReg   = 1'b0;
      ALU_op     = '0;
      MemWrite   = 1'b0;
      ALUSrc     = 1'b0;
      alu_branch = '0;
      RegWrite   = 1'b0;
      fetchPC    = FPC_SEQ;
    end
  end

  always_comb begin
    count_d = '0;
    if ((MEM_TIMEOUT != 0) && mem_req && !mem_ready && (state_d == state_q)) begin
      count_d = count_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ir_q    <= RESET_IR;
      count_q <= '0;
      trap_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
      if (ir_write) ir_q <= instr_rdata;
    end
  end

  assign trap       = trap_q && !reset;
  assign trap_cause = reset ? CAUSE_NONE : cause_q;
  assign state      = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: per-cycle state traces and
// control-strobe checks against hand-computed values, two parameterisations.
module tb_multicycle_main_control;

  localparam logic [31:0] I_ADDI  = 32'h0050_0093;
  localparam logic [31:0] I_LW    = 32'h0000_2083;
  localparam logic [31:0] I_SW    = 32'h0031_2023;
  localparam logic [31:0] I_BEQ   = 32'h0000_0063;
  localparam logic [31:0] I_BLT   = 32'h0000_4063;
  localparam logic [31:0] I_JAL   = 32'h0000_00EF;
  localparam logic [31:0] I_JALR  = 32'h0001_00E7;
  localparam logic [31:0] I_SUB   = 32'h4031_00B3;
  localparam logic [31:0] I_SRAI  = 32'h4031_5093;
  localparam logic [31:0] I_MUL   = 32'h0231_00B3;
  localparam logic [31:0] I_BADF7 = 32'h0A31_00B3;
  localparam logic [31:0] I_BADOP = 32'h0000_007F;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_ready, stall;
  logic [31:0] instr_rdata;

  logic       mem_req, ir_write, pc_write, Branch, MemRead, MemtoReg, MemWrite, ALUSrc;
  logic       RegWrite, trap;
  logic [4:0] ALU_op;
  logic [2:0] alu_branch, state;
  logic [1:0] fetchPC, trap_cause;

  logic       n_mem_req, n_ir_write, n_pc_write, n_Branch, n_MemRead, n_MemtoReg;
  logic       n_MemWrite, n_ALUSrc, n_RegWrite, n_trap;
  logic [4:0] n_ALU_op;
  logic [2:0] n_alu_branch, n_state;
  logic [1:0] n_fetchPC, n_trap_cause;

  multicycle_main_control #(.ENABLE_M(1'b1), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .instr_rdata(instr_rdata), .mem_ready(mem_ready), .stall(stall),
    .mem_req(mem_req), .ir_write(ir_write), .pc_write(pc_write), .Branch(Branch),
    .MemRead(MemRead), .MemtoReg(MemtoReg), .ALU_op(ALU_op), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .alu_branch(alu_branch), .RegWrite(RegWrite), .fetchPC(fetchPC),
    .trap(trap), .trap_cause(trap_cause), .state(state)
  );

  multicycle_main_control #(.ENABLE_M(1'b0), .MEM_TIMEOUT(0)) dut_nom (
    .clk(clk), .reset(reset), .instr_rdata(instr_rdata), .mem_ready(mem_ready), .stall(stall),
    .mem_req(n_mem_req), .ir_write(n_ir_write), .pc_write(n_pc_write), .Branch(n_Branch),
    .MemRead(n_MemRead), .MemtoReg(n_MemtoReg), .ALU_op(n_ALU_op), .MemWrite(n_MemWrite),
    .ALUSrc(n_ALUSrc), .alu_branch(n_alu_branch), .RegWrite(n_RegWrite), .fetchPC(n_fetchPC),
    .trap(n_trap), .trap_cause(n_trap_cause), .state(n_state)
  );

  // scoreboard
  logic [2:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    mem_ready   = 1'b0;
    stall       = 1'b0;
    instr_rdata = 32'h0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Completes a zero-wait fetch; returns in the DECODE cycle.
  task automatic fetch(input logic [31:0] instr);
    instr_rdata = instr;
    mem_ready   = 1'b1;
    #1;
    check("fetch_state", state, 3'd0);
    check("fetch_ir_write", ir_write, 1'b1);
    check("fetch_mem_req", mem_req, 1'b1);
    tick();
    mem_ready   = 1'b0;
    instr_rdata = 32'hDEAD_BEEF;
    #1;
  endtask

  task automatic run_to_exec(input logic [31:0] instr);
    do_reset();
    fetch(instr);
    tick();
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; stall = 1'b0; instr_rdata = I_ADDI;
    #1;
    check("rst_state", state, 3'd0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_ir_write", ir_write, 1'b0);
    tick();
    check("rst_after_trap", trap, 1'b0);

    // ADDI with zero-wait fetch: 0,1,2,4,0
    do_reset();
    exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    exp_q.push_back(3'd4); exp_q.push_back(3'd0);
    for (int i = 0; i < 5; i++) begin
      mem_ready   = (i == 0);
      instr_rdata = (i == 0) ? I_ADDI : 32'hDEAD_BEEF;
      #1;
      check("addi_state", state, exp_q.pop_front());
      check("addi_regwrite", RegWrite, i == 3);
      if (i == 2) begin
        check("addi_alu_op", ALU_op, 5'b00000);
        check("addi_alusrc", ALUSrc, 1'b1);
      end
      if (i == 3) check("addi_fetchpc", fetchPC, 2'b00);
      tick();
    end

    // LW, ready delayed 3 cycles in MEM: 8 cycles total
    do_reset();
    exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    exp_q.push_back(3'd3); exp_q.push_back(3'd3); exp_q.push_back(3'd3);
    exp_q.push_back(3'd3); exp_q.push_back(3'd4); exp_q.push_back(3'd0);
    for (int i = 0; i < 9; i++) begin
      mem_ready   = (i == 0) || (i == 6);
      instr_rdata = (i == 0) ? I_LW : 32'hDEAD_BEEF;
      #1;
      check("lw_state", state, exp_q.pop_front());
      check("lw_memread", MemRead, (i == 0) || (i >= 3 && i <= 6) || (i == 8));
      check("lw_regwrite", RegWrite, i == 7);
      check("lw_memtoreg", MemtoReg, i == 7);
      check("lw_trap", trap, 1'b0);
      tick();
    end

    // SW: memory write then PC+4
    run_to_exec(I_SW);
    check("sw_alusrc", ALUSrc, 1'b1);
    tick();
    mem_ready = 1'b1;
    #1;
    check("sw_state", state, 3'd3);
    check("sw_memwrite", MemWrite, 1'b1);
    check("sw_memread", MemRead, 1'b0);
    check("sw_pc_write", pc_write, 1'b1);
    tick();
    check("sw_done_state", state, 3'd0);

    // BEQ and BLT
    run_to_exec(I_BEQ);
    check("beq_branch", Branch, 1'b1);
    check("beq_alu_branch", alu_branch, 3'b000);
    check("beq_alu_op", ALU_op, 5'b01000);
    check("beq_pc_write", pc_write, 1'b1);
    check("beq_fetchpc", fetchPC, 2'b01);
    check("beq_alusrc", ALUSrc, 1'b0);
    tick();
    check("beq_back_fetch", state, 3'd0);
    run_to_exec(I_BLT);
    check("blt_alu_branch", alu_branch, 3'b100);

    // R/I ALU_op encodings
    run_to_exec(I_SUB);
    check("sub_alu_op", ALU_op, 5'b01000);
    check("sub_alusrc", ALUSrc, 1'b0);
    run_to_exec(I_SRAI);
    check("srai_alu_op", ALU_op, 5'b01101);
    run_to_exec(I_BADF7);
    check("badf7_state", state, 3'd7);
    check("badf7_cause", trap_cause, 2'b01);

    // MUL: M decode on dut, illegal on dut_nom
    run_to_exec(I_MUL);
    check("mul_state", state, 3'd2);
    check("mul_alu_op", ALU_op, 5'b10000);
    check("mul_nom_state", n_state, 3'd7);
    check("mul_nom_cause", n_trap_cause, 2'b01);

    // JAL / JALR writeback PC select, with a stall in WRITEBACK
    run_to_exec(I_JAL);
    tick();
    check("jal_fetchpc", fetchPC, 2'b01);
    check("jal_regwrite", RegWrite, 1'b1);
    run_to_exec(I_JALR);
    tick();
    stall = 1'b1;
    #1;
    check("jalr_stall_state", state, 3'd4);
    check("jalr_stall_regwrite", RegWrite, 1'b0);
    check("jalr_stall_pc_write", pc_write, 1'b0);
    tick();
    stall = 1'b0;
    #1;
    check("jalr_state", state, 3'd4);
    check("jalr_fetchpc", fetchPC, 2'b10);
    check("jalr_pc_write", pc_write, 1'b1);
    tick();
    check("jalr_done", state, 3'd0);

    // Stall in EXECUTE for 2 cycles on a branch
    run_to_exec(I_BEQ);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stall_state", state, 3'd2);
      check("stall_pc_write", pc_write, 1'b0);
      tick();
    end
    stall = 1'b0;
    #1;
    check("stall_resume_state", state, 3'd2);
    check("stall_resume_pc_write", pc_write, 1'b1);
    tick();
    check("stall_resume_fetch", state, 3'd0);

    // Illegal opcode: sticky TRAP until reset
    run_to_exec(I_BADOP);
    check("ill_state", state, 3'd7);
    check("ill_trap", trap, 1'b1);
    check("ill_cause", trap_cause, 2'b01);
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ill_hold_state", state, 3'd7);
      check("ill_hold_mem_req", mem_req, 1'b0);
    end
    reset = 1'b1;
    #1;
    check("ill_rst_trap", trap, 1'b0);
    tick();
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("ill_rst_state", state, 3'd0);
    check("ill_rst_cause", trap_cause, 2'b00);

    // Fetch timeout after 4 unanswered cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check("to_state", state, 3'd0);
      check("to_mem_req", mem_req, 1'b1);
      tick();
    end
    check("to_trap_state", state, 3'd7);
    check("to_cause", trap_cause, 2'b10);
    check("to_nom_state", n_state, 3'd0);

    // Reset in WRITEBACK suppresses the write
    run_to_exec(I_ADDI);
    tick();
    reset = 1'b1;
    #1;
    check("midrst_regwrite", RegWrite, 1'b0);
    check("midrst_pc_write", pc_write, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check("midrst_state", state, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
